// File: rtl/dds_fifo_slave.sv
// Avalon-MM slave feeding a show-ahead command FIFO toward a DDS serializer.
// Registers: CTRL (enable/flush), STATUS (empty/full/level), DATA (push),
// COUNT (words delivered). Reads return two cycles after acceptance.
module dds_fifo_slave #(
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        endofpacket,
  output logic [31:0] dds_data,
  output logic        dds_valid,
  input  logic        dds_ready
);

  localparam int AW = LW - 1;

  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_STATUS = 6'd1;
  localparam logic [5:0] IDX_DATA   = 6'd2;
  localparam logic [5:0] IDX_COUNT  = 6'd3;

  logic [5:0]    idx;
  logic          wr_acc;
  logic          rd_acc;
  logic          ctrl_wr;
  logic          flush;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;

  logic [31:0]   mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic          enable_q, enable_d;
  logic [31:0]   count_q, count_d;

  logic          vld_p1_q;
  logic [5:0]    idx_p1_q;
  logic          vld_p2_q;
  logic [31:0]   rdata_p2_q;
  logic [31:0]   rdata_mux;

  // Byte-offset bits and the upper CTRL byte lanes carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{address[1:0], byteenable[3:1]};

  assign idx   = address[7:2];
  // Wrapping pointers: the difference is the fill level, 0..DEPTH.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Only a DATA push into a full FIFO stalls; a same-cycle pop does not help.
  assign waitrequest = write && (idx == IDX_DATA) && full;
  assign wr_acc      = write && !waitrequest;
  // A simultaneous read+write is treated as the write alone.
  assign rd_acc      = read && !write;

  assign ctrl_wr = wr_acc && (idx == IDX_CTRL);
  assign flush   = ctrl_wr && byteenable[0] && writedata[1];
  assign push    = wr_acc && (idx == IDX_DATA) && !flush;

  assign dds_valid = enable_q && !empty;
  assign dds_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop       = dds_valid && dds_ready;

  assign endofpacket   = 1'b0;
  assign readdata      = rdata_p2_q;
  assign readdatavalid = vld_p2_q;

  // Next-state for pointers, enable and delivered-word counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    enable_d = enable_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (ctrl_wr && byteenable[0]) enable_d = writedata[0];
    // A COUNT write wins over a same-cycle delivery.
    if (wr_acc && (idx == IDX_COUNT)) count_d = '0;
    else if (pop)                      count_d = count_q + 32'd1;
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      enable_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      enable_q <= enable_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= writedata;
  end

  // Register read mux, evaluated on the stage-1 index against current state.
  always_comb begin
    rdata_mux = '0;
    case (idx_p1_q)
      IDX_CTRL:   rdata_mux = {31'b0, enable_q};
      IDX_STATUS: rdata_mux = {{(28-LW){1'b0}}, level, 2'b00, full, empty};
      IDX_COUNT:  rdata_mux = count_q;
      default:    rdata_mux = '0;
    endcase
  end

  // Stage 1: capture an accepted read and its index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      idx_p1_q <= '0;
    end else begin
      vld_p1_q <= rd_acc;
      idx_p1_q <= idx;
    end
  end

  // Stage 2: register the selected data together with its valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2_q   <= 1'b0;
      rdata_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) rdata_p2_q <= rdata_mux;
    end
  end

endmodule

// File: tb/tb_dds_fifo_slave.sv
// Randomized bench for dds_fifo_slave against a queue-based reference model.
module tb_dds_fifo_slave;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        endofpacket;
  logic [31:0] dds_data;
  logic        dds_valid;
  logic        dds_ready;

  dds_fifo_slave #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .endofpacket(endofpacket), .dds_data(dds_data), .dds_valid(dds_valid),
    .dds_ready(dds_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a queue, plus register values and the
  // single expected read response scheduled for the next cycle.
  logic [31:0] mq [$];
  bit          m_en;
  logic [31:0] m_cnt;
  bit          m_p1v;
  logic [5:0]  m_p1i;
  bit          m_rv;
  logic [31:0] m_rd;
  bit          m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_regval(input logic [5:0] i);
    logic [31:0] v;
    int lvl;
    v = 32'd0;
    lvl = mq.size();
    case (i)
      6'd0: v = {31'b0, m_en};
      6'd1: begin
        v = 32'(lvl) << 4;
        v[1] = (lvl == DEPTH);
        v[0] = (lvl == 0);
      end
      6'd3: v = m_cnt;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_en  = 1'b0;
    m_cnt = 32'd0;
    m_p1v = 1'b0;
    m_p1i = 6'd0;
    m_rv  = 1'b0;
    m_rd  = 32'd0;
  endtask

  // One bus cycle: drive, check outputs at the falling edge, advance model.
  task automatic cyc(input bit rd, input bit wr, input logic [5:0] i,
                     input logic [3:0] be, input logic [31:0] wd, input bit rdy);
    bit full, wreq, dv;
    read       = rd;
    write      = wr;
    address    = {i, 2'($urandom)};
    byteenable = be;
    writedata  = wd;
    dds_ready  = rdy;
    @(negedge clk);
    full = (mq.size() == DEPTH);
    wreq = wr && (i == 6'd2) && full;
    dv   = m_en && (mq.size() != 0);
    chk("waitrequest", {31'b0, waitrequest}, {31'b0, wreq});
    chk("dds_valid", {31'b0, dds_valid}, {31'b0, dv});
    if (dv) chk("dds_data", dds_data, mq[0]);
    chk("readdatavalid", {31'b0, readdatavalid}, {31'b0, m_rv});
    if (m_rv) chk("readdata", readdata, m_rd);
    chk("endofpacket", {31'b0, endofpacket}, 32'd0);
    m_acc = wr && !wreq;
    m_rv = m_p1v;
    if (m_p1v) m_rd = m_regval(m_p1i);
    m_p1v = rd && !wr;
    m_p1i = i;
    if (dv && rdy) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    if (m_acc) begin
      case (i)
        6'd0: begin
          if (be[0]) m_en = wd[0];
          if (be[0] && wd[1]) mq.delete();
        end
        6'd2: mq.push_back(wd);
        6'd3: m_cnt = 32'd0;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 6'd0, 4'h0, 32'd0, rdy);
  endtask

  task automatic rd_reg(input logic [5:0] i);
    cyc(1'b1, 1'b0, i, 4'h0, 32'd0, 1'b0);
  endtask

  // Hold a DATA write until accepted, with a bounded number of attempts.
  task automatic push_hold(input logic [31:0] wd, input bit rdy);
    int k;
    k = 0;
    m_acc = 1'b0;
    while (!m_acc && k < 64) begin
      cyc(1'b0, 1'b1, 6'd2, 4'hF, wd, rdy);
      k++;
    end
    if (!m_acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdv"}, {31'b0, readdatavalid}, 32'd0);
    chk({tag, "_readdata"}, readdata, 32'd0);
    chk({tag, "_dds_valid"}, {31'b0, dds_valid}, 32'd0);
    chk({tag, "_waitrequest"}, {31'b0, waitrequest}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'd0;
    byteenable = 4'h0; writedata = 32'd0; dds_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Status after reset: empty only.
    rd_reg(6'd1);
    idle(3, 1'b0);

    // Fill with enable off, stall the 17th push, then enable and retry.
    for (int k = 0; k < DEPTH; k++) push_hold($urandom, 1'b1);
    d = $urandom;
    cyc(1'b0, 1'b1, 6'd2, 4'hF, d, 1'b1);
    cyc(1'b0, 1'b1, 6'd2, 4'hF, d, 1'b1);
    cyc(1'b0, 1'b1, 6'd0, 4'h1, 32'd1, 1'b1);
    push_hold(d, 1'b1);
    idle(20, 1'b1);
    rd_reg(6'd3);
    idle(3, 1'b1);

    // Back-to-back reads of several indices.
    rd_reg(6'd0); rd_reg(6'd1); rd_reg(6'd3); rd_reg(6'd5);
    idle(3, 1'b0);

    // Push every cycle while the sink alternates ready.
    d = $urandom;
    for (int k = 0; k < 48; k++) begin
      cyc(1'b0, 1'b1, 6'd2, 4'hF, d, (k % 2) == 0);
      if (m_acc) d = $urandom;
    end
    idle(40, 1'b1);

    // Flush with five words queued and a same-cycle pop.
    cyc(1'b0, 1'b1, 6'd0, 4'h1, 32'd1, 1'b0);
    for (int k = 0; k < 5; k++) push_hold($urandom, 1'b0);
    cyc(1'b0, 1'b1, 6'd0, 4'h1, 32'd3, 1'b1);
    rd_reg(6'd1);
    rd_reg(6'd3);
    idle(3, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      int op;
      bit rdy;
      logic [5:0] ri;
      logic [31:0] wd;
      op  = $urandom_range(0, 19);
      rdy = ($urandom_range(0, 3) != 0);
      ri  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      wd  = $urandom;
      if (op <= 3) cyc(1'b1, 1'b0, ri, 4'($urandom), wd, rdy);
      else if (op == 4) cyc(1'b1, 1'b1, 6'd2, 4'($urandom), wd, rdy);
      else if (op <= 10) cyc(1'b0, 1'b1, 6'd2, 4'($urandom), wd, rdy);
      else if (op == 11) begin
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 15) == 0);
        cyc(1'b0, 1'b1, 6'd0, 4'($urandom), wd, rdy);
      end else if (op == 12 && $urandom_range(0, 3) == 0)
        cyc(1'b0, 1'b1, 6'd3, 4'($urandom), wd, rdy);
      else if (op == 13) cyc(1'b0, 1'b1, 6'($urandom_range(4, 63)), 4'hF, wd, rdy);
      else cyc(1'b0, 1'b0, ri, 4'h0, wd, rdy);
    end
    idle(4, 1'b0);

    // Reset mid-stream with a full FIFO and two reads in flight.
    cyc(1'b0, 1'b1, 6'd0, 4'h1, 32'd0, 1'b0);
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 1'b1, 6'd2, 4'hF, $urandom, 1'b0);
    cyc(1'b0, 1'b1, 6'd0, 4'h1, 32'd1, 1'b0);
    rd_reg(6'd1);
    rd_reg(6'd3);
    reset = 1'b1;
    read = 1'b0; write = 1'b1; address = {6'd2, 2'b00}; dds_ready = 1'b1;
    #1;
    check_reset_outputs("midrst");
    m_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    write = 1'b0;
    reset = 1'b0;
    idle(4, 1'b1);
    cyc(1'b0, 1'b1, 6'd0, 4'h1, 32'd1, 1'b0);
    for (int k = 0; k < 3; k++) push_hold($urandom, 1'b0);
    idle(6, 1'b1);
    rd_reg(6'd3);
    rd_reg(6'd1);
    idle(3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
